// File: rtl/ir_pkg.sv
// -----------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the IR line-sensor conditioner:
//   IR_N_CH_DEF    default channel count of the sensor bar
//   pos_w(n)       width of the signed position word for n channels
//   ir_evt_state_t states of the change-event handshake machine
// -----------------------------------------------------------------------------
package ir_pkg;

    localparam int IR_N_CH_DEF = 5;

    // Position spans -(n-1)..+(n-1); one extra bit carries the sign.
    function automatic int pos_w(input int n);
        return $clog2(2 * n - 1) + 1;
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ir_evt_state_t;

endpackage

// File: rtl/ir_line_sensor_conditioner_if.sv
// -----------------------------------------------------------------------------
// ir_line_sensor_conditioner_if
// Bus between the sensor pads / CPU register bank and the conditioner.
//   ir_raw, en, cfg_debounce, evt_ack        : driven by the master side
//   ir_state, ir_changed, evt_pending,
//   line_lost, position, pos_valid           : driven by the conditioner
// Modports: master (pads/CPU side), slave (conditioner).
// -----------------------------------------------------------------------------
interface ir_line_sensor_conditioner_if #(
    parameter int N_CH  = ir_pkg::IR_N_CH_DEF,
    parameter int DB_W  = 16,
    parameter int POS_W = ir_pkg::pos_w(N_CH)
) ();

    logic [N_CH-1:0]         ir_raw;
    logic                    en;
    logic [DB_W-1:0]         cfg_debounce;
    logic                    evt_ack;
    logic [N_CH-1:0]         ir_state;
    logic                    ir_changed;
    logic                    evt_pending;
    logic                    line_lost;
    logic signed [POS_W-1:0] position;
    logic                    pos_valid;

    modport master (
        output ir_raw, en, cfg_debounce, evt_ack,
        input  ir_state, ir_changed, evt_pending, line_lost, position, pos_valid
    );

    modport slave (
        input  ir_raw, en, cfg_debounce, evt_ack,
        output ir_state, ir_changed, evt_pending, line_lost, position, pos_valid
    );

endinterface

// File: rtl/ir_debounce_ch.sv
// -----------------------------------------------------------------------------
// ir_debounce_ch
// One sensor channel: synchroniser chain, polarity correction and a debounce
// counter that accepts a new level only after it has differed from the
// accepted level for more than cfg_debounce_i consecutive enabled cycles.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   raw_i             raw pin, asynchronous to clk
//   en_i              0: hold counter and accepted level (sync keeps running)
//   cfg_debounce_i    hold time in cycles
//   state_o           accepted (debounced) level, 1 = line detected
// -----------------------------------------------------------------------------
module ir_debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            raw_i,
    input  logic            en_i,
    input  logic [DB_W-1:0] cfg_debounce_i,
    output logic            state_o
);

    localparam bit POL = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ POL;

    // The counter only increments while below the threshold, so it can never
    // wrap; lowering the threshold below a running count commits on the next
    // differing cycle through the >= branch.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (en_i) begin
            if (s == state_q) begin
                cnt_d = '0;
            end else if (cnt_q < cfg_debounce_i) begin
                cnt_d = cnt_q + DB_W'(1);
            end else begin
                state_d = s;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ir_line_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// ir_line_sensor_conditioner
// Front end for the IR line-following sensor bar: per-channel synchronise and
// debounce, change pulse, sticky change event with ack, line-lost flag and an
// optional signed line-position encoder.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        ir_line_sensor_conditioner_if.slave
//              (ir_raw, en, cfg_debounce, evt_ack in;
//               ir_state, ir_changed, evt_pending, line_lost,
//               position, pos_valid out)
// Configuration macro:
//   IR_POSITION_EN  defined: position/pos_valid come from the encoder;
//                   undefined: both tied to 0 and no encoder is built.
// -----------------------------------------------------------------------------
module ir_line_sensor_conditioner
    import ir_pkg::*;
#(
    parameter int N_CH        = IR_N_CH_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    ir_line_sensor_conditioner_if.slave    bus
);

    logic [N_CH-1:0] ir_state;
    logic [N_CH-1:0] prev_q;
    logic            changed_q;
    ir_evt_state_t   evt_state_q, evt_state_d;
    logic            evt_pending;

    // ---------------- per-channel filters ----------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            ir_debounce_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_W        (DB_W),
                .ACTIVE_LOW  (ACTIVE_LOW)
            ) u_ch (
                .clk            (clk),
                .rst            (rst),
                .raw_i          (bus.ir_raw[gi]),
                .en_i           (bus.en),
                .cfg_debounce_i (bus.cfg_debounce),
                .state_o        (ir_state[gi])
            );
        end
    endgenerate

    // ---------------- change detector ----------------
    // prev_q trails ir_state by one cycle, so changed_q rises in the cycle
    // after ir_state moves; simultaneous channel changes merge into one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            prev_q    <= ir_state;
            changed_q <= (ir_state != prev_q);
        end
    end

    // ---------------- event state machine ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_state_q <= IDLE;
        end else begin
            evt_state_q <= evt_state_d;
        end
    end

    // An ack coinciding with a fresh change must not lose that change.
    always_comb begin
        evt_state_d = evt_state_q;
        case (evt_state_q)
            IDLE:    if (changed_q) evt_state_d = PENDING;
            PENDING: if (bus.evt_ack && !changed_q) evt_state_d = IDLE;
            default: evt_state_d = IDLE;
        endcase
    end

    always_comb begin
        evt_pending = 1'b0;
        if (evt_state_q == PENDING) evt_pending = 1'b1;
    end

    assign bus.ir_state    = ir_state;
    assign bus.ir_changed  = changed_q;
    assign bus.evt_pending = evt_pending;
    assign bus.line_lost   = ~|ir_state;

    // ---------------- optional position encoder ----------------
`ifdef IR_POSITION_EN
    localparam int POS_W = pos_w(N_CH);

    int                      lo, hi;
    logic signed [POS_W-1:0] pos_d;
    logic signed [POS_W-1:0] pos_q;
    logic                    pos_valid_q;

    // lo/hi are the outermost detected channels; their sum minus (N_CH-1)
    // is twice the offset of the line centre from the bar centre.
    always_comb begin
        lo = 0;
        hi = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ir_state[i]) lo = i;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (ir_state[i]) hi = i;
        end
        pos_d = POS_W'(lo + hi - (N_CH - 1));
    end

    // Position keeps its last value while the line is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
        end else begin
            pos_valid_q <= |ir_state;
            if (|ir_state) pos_q <= pos_d;
        end
    end

    assign bus.position  = pos_q;
    assign bus.pos_valid = pos_valid_q;
`else
    assign bus.position  = '0;
    assign bus.pos_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ir_line_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_ir_line_sensor_conditioner
// Directed scenarios followed by a randomized phase, every cycle compared
// against a behavioural model: raw samples travel through a fixed-length
// queue, each channel accepts a new level once it has disagreed for more than
// cfg_debounce consecutive enabled cycles, and the event flag follows the
// set/ack rules. Honours IR_POSITION_EN.
// -----------------------------------------------------------------------------
module tb_ir_line_sensor_conditioner;

    localparam int N    = 5;
    localparam int SYNC = 2;
    localparam int DBW  = 16;
    localparam int AL   = 0;
    localparam int PW   = ir_pkg::pos_w(N);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ir_line_sensor_conditioner_if #(.N_CH(N), .DB_W(DBW), .POS_W(PW)) bus ();

    ir_line_sensor_conditioner #(
        .N_CH(N), .SYNC_STAGES(SYNC), .DB_W(DBW), .ACTIVE_LOW(AL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [N-1:0]         hist[$];
    logic [N-1:0]         m_state, m_prev;
    int                   m_run[N];
    bit                   m_changed, m_pending, m_pv;
    logic signed [PW-1:0] m_pos;

    task automatic model_reset();
        hist = {};
        for (int k = 0; k < SYNC; k++) hist.push_back('0);
        m_state   = '0;
        m_prev    = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_changed = 1'b0;
        m_pending = 1'b0;
        m_pv      = 1'b0;
        m_pos     = '0;
    endtask

    function automatic int line_pos(input logic [N-1:0] v);
        int lo = -1, hi = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        return lo + hi - (N - 1);
    endfunction

    // Called right after a rising edge; inputs still hold their pre-edge values.
    task automatic model_edge();
        logic [N-1:0] s;
        bit           new_changed, new_pending;
        s = hist[0] ^ {N{AL != 0}};
        void'(hist.pop_front());
        hist.push_back(bus.ir_raw);
        new_changed = (m_state != m_prev);
        new_pending = m_pending ? !(bus.evt_ack && !m_changed) : m_changed;
        if (m_state != 0) begin
            m_pos = PW'(line_pos(m_state));
            m_pv  = 1'b1;
        end else begin
            m_pv  = 1'b0;
        end
        m_prev = m_state;
        if (bus.en) begin
            for (int i = 0; i < N; i++) begin
                if (s[i] == m_state[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] > int'(bus.cfg_debounce)) begin
                        m_state[i] = s[i];
                        m_run[i]   = 0;
                    end
                end
            end
        end
        m_changed = new_changed;
        m_pending = new_pending;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ir_state"},    32'(bus.ir_state),    32'(m_state));
        chk({tag, ".ir_changed"},  32'(bus.ir_changed),  32'(m_changed));
        chk({tag, ".evt_pending"}, 32'(bus.evt_pending), 32'(m_pending));
        chk({tag, ".line_lost"},   32'(bus.line_lost),   32'(m_state == 0));
`ifdef IR_POSITION_EN
        chk({tag, ".position"},    32'($unsigned(bus.position)), 32'($unsigned(m_pos)));
        chk({tag, ".pos_valid"},   32'(bus.pos_valid),   32'(m_pv));
`else
        chk({tag, ".position"},    32'($unsigned(bus.position)), 32'd0);
        chk({tag, ".pos_valid"},   32'(bus.pos_valid),   32'd0);
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all(tag);
    endtask

    logic signed [PW-1:0] exp_pos;
    bit                   seen;

    initial begin
        bus.ir_raw       = '0;
        bus.en           = 1'b1;
        bus.cfg_debounce = 16'd3;
        bus.evt_ack      = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        step("reset");
        step("reset");
        rst = 1'b0;

        // 1: latency SYNC + cfg + 1 = 6 edges, single change pulse
        bus.ir_raw = 5'b00100;
        for (int c = 1; c <= 10; c++) begin
            step("t1");
            if (c == 5) chk("t1_not_yet", 32'(bus.ir_state), 32'd0);
            if (c == 6) chk("t1_latency", 32'(bus.ir_state), 32'(5'b00100));
            if (c == 7) chk("t1_pulse", 32'(bus.ir_changed), 32'd1);
            if (c == 8) chk("t1_one_pulse", 32'(bus.ir_changed), 32'd0);
        end
`ifdef IR_POSITION_EN
        chk("t1_pos_valid", 32'(bus.pos_valid), 32'd1);
`endif
        chk("t1_position", 32'($unsigned(bus.position)), 32'd0);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        bus.ir_raw = 5'b00101;
        repeat (3) step("t2_glitch");
        bus.ir_raw = 5'b00100;
        repeat (10) step("t2_glitch");
        chk("t2_rejected", 32'(bus.ir_state), 32'(5'b00100));
        bus.ir_raw = 5'b00101;
        repeat (4) step("t2_pulse");
        bus.ir_raw = 5'b00100;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step("t2_pulse");
            if (bus.ir_state == 5'b00101) seen = 1'b1;
        end
        chk("t2_accepted", 32'(seen), 32'd1);

        // 3: position encoding at the extremes
        bus.ir_raw = 5'b11000;
        repeat (10) step("t3_left");
`ifdef IR_POSITION_EN
        exp_pos = 3;
`else
        exp_pos = 0;
`endif
        chk("t3_pos_plus3", 32'($unsigned(bus.position)), 32'($unsigned(exp_pos)));
        bus.ir_raw = 5'b00001;
        repeat (10) step("t3_right");
`ifdef IR_POSITION_EN
        exp_pos = -4;
`endif
        chk("t3_pos_minus4", 32'($unsigned(bus.position)), 32'($unsigned(exp_pos)));

        // 4: ack coinciding with a change keeps the event pending
        chk("t4_pending_before", 32'(bus.evt_pending), 32'd1);
        bus.ir_raw = 5'b00011;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step("t4_wait");
            seen = bus.ir_changed;
        end
        chk("t4_change_seen", 32'(seen), 32'd1);
        bus.evt_ack = 1'b1;
        step("t4_ack_change");
        bus.evt_ack = 1'b0;
        chk("t4_still_pending", 32'(bus.evt_pending), 32'd1);
        step("t4_idle");
        bus.evt_ack = 1'b1;
        step("t4_lone_ack");
        bus.evt_ack = 1'b0;
        chk("t4_cleared", 32'(bus.evt_pending), 32'd0);

        // 5: line lost, then en=0 freezes an incoming edge
        bus.ir_raw = 5'b00000;
        repeat (10) step("t5_lost");
        chk("t5_line_lost", 32'(bus.line_lost), 32'd1);
        chk("t5_pos_valid", 32'(bus.pos_valid), 32'd0);
        bus.en     = 1'b0;
        bus.ir_raw = 5'b00100;
        repeat (10) step("t5_frozen");
        chk("t5_frozen", 32'(bus.ir_state), 32'd0);
        bus.en = 1'b1;
        repeat (6) step("t5_thaw");
        chk("t5_thawed", 32'(bus.ir_state), 32'(5'b00100));

        // 6: asynchronous reset in the middle of a count
        bus.ir_raw = 5'b11111;
        repeat (3) step("t6_count");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_rst");
        step("t6_rst");
        bus.ir_raw = '0;
        step("t6_rst");
        rst = 1'b0;
        repeat (4) step("t6_after");

        // cfg_debounce = 0: state follows the synchronised input one edge later
        bus.cfg_debounce = 16'd0;
        bus.ir_raw       = 5'b01110;
        for (int c = 1; c <= 4; c++) begin
            step("cfg0");
            if (c == 3) chk("cfg0_latency", 32'(bus.ir_state), 32'(5'b01110));
        end

        // randomized phase
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) < 2) bus.ir_raw = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 29) == 0) bus.cfg_debounce = DBW'($urandom_range(0, 5));
            bus.en      = ($urandom_range(0, 9) != 0);
            bus.evt_ack = ($urandom_range(0, 4) == 0);
            if (c == 700) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rnd_async_rst");
                step("rnd_rst");
                rst = 1'b0;
            end
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
